// File: rtl/rtg_pkg.sv
// Shared types and constants for the random-test-generation campaign sequencer.
// Holds the FSM state enum, the LFSR feedback mask and the LFSR step function.
package rtg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GEN,
        SCAN,
        INJECT,
        CMP,
        REMOVE,
        ACCUM,
        EMIT,
        CHECK,
        DONE
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_MASK     = 32'h8020_0003;
    // An all-zero seed would lock the LFSR up
    localparam logic [31:0] SEED_ZERO_SUB = 32'h0000_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) begin
            n = n ^ LFSR_MASK;
        end
        return n;
    endfunction

endpackage

// File: rtl/rtg_lfsr32.sv
// 32-bit Galois LFSR used as the test-vector source.
// Ports: clk, rst (sync, high), enable (advance), load (take seed), seed, state.
module rtg_lfsr32
    import rtg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 32'h0000_0001;
        end else if (load) begin
            state <= (seed == 32'h0) ? SEED_ZERO_SUB : seed;
        end else if (enable) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/rtg_campaign_ctrl.sv
// Fault-simulation campaign sequencer: generates random vectors, walks the
// fault list with fault dropping, injects/compares each fault, emits useful
// vectors over valid/ready and stops on coverage or a useless-vector limit.
// Ports: clk, rst, start, seed | test_vec, fault_idx, inject | good_out,
// fault_out | vec_valid, vec_ready | busy, done, cov_met, det_total,
// vec_count, useless_cnt.
module rtg_campaign_ctrl
    import rtg_pkg::*;
#(
    parameter int NUM_FAULTS = 1798,
    parameter int VEC_W      = 157,
    parameter int OUT_W      = 64,
    parameter int EF_COUNT   = 1,
    parameter int UT_LIMIT   = 300,
    parameter int COV_PCT    = 95,
    parameter int SETTLE     = 6,
    parameter int IDX_W      = $clog2(NUM_FAULTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    output logic [VEC_W-1:0] test_vec,
    output logic [IDX_W-1:0] fault_idx,
    output logic             inject,
    input  logic [OUT_W-1:0] good_out,
    input  logic [OUT_W-1:0] fault_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic             cov_met,
    output logic [IDX_W:0]   det_total,
    output logic [15:0]      vec_count,
    output logic [15:0]      useless_cnt
);

    localparam int              GEN_WORDS   = (VEC_W + 31) / 32;
    localparam logic [7:0]      GEN_LAST    = 8'(GEN_WORDS - 1);
    localparam logic [15:0]     SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [IDX_W:0]  FAULT_END   = (IDX_W+1)'(NUM_FAULTS);
    localparam logic [IDX_W:0]  EF_MIN      = (IDX_W+1)'(EF_COUNT);
    localparam logic [15:0]     UT_MAX      = 16'(UT_LIMIT);
    localparam logic [IDX_W+7:0] COV_THR    = (IDX_W+8)'(COV_PCT * NUM_FAULTS);

    state_t                state_q, state_d;
    logic [VEC_W-1:0]      tv_q, tv_d;
    // One bit wider than fault_idx so it can hold NUM_FAULTS as the end marker
    logic [IDX_W:0]        idx_q, idx_d;
    logic [7:0]            gen_q, gen_d;
    logic [15:0]           set_q, set_d;
    logic [IDX_W:0]        ctc_q, ctc_d;
    logic [NUM_FAULTS-1:0] at_q, at_d;
    logic [NUM_FAULTS-1:0] ct_q, ct_d;
    logic [IDX_W:0]        det_q, det_d;
    logic [15:0]           vc_q, vc_d;
    logic [15:0]           uc_q, uc_d;
    logic                  cov_q, cov_d;

    logic                  lfsr_load;
    logic                  lfsr_en;
    logic [31:0]           lfsr_state;
    logic [31:0]           lfsr_word;
    logic [IDX_W-1:0]      fidx;
    logic [IDX_W+7:0]      cov_lhs;

    rtg_lfsr32 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (lfsr_en),
        .load   (lfsr_load),
        .seed   (seed),
        .state  (lfsr_state)
    );

    // GEN consumes the value the LFSR steps to in the same cycle
    assign lfsr_word = lfsr_step(lfsr_state);
    assign fidx      = idx_q[IDX_W-1:0];
    assign cov_lhs   = (IDX_W+8)'(det_q) * (IDX_W+8)'(100);

    always_comb begin
        state_d   = state_q;
        tv_d      = tv_q;
        idx_d     = idx_q;
        gen_d     = gen_q;
        set_d     = set_q;
        ctc_d     = ctc_q;
        at_d      = at_q;
        ct_d      = ct_q;
        det_d     = det_q;
        vc_d      = vc_q;
        uc_d      = uc_q;
        cov_d     = cov_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    at_d      = '0;
                    det_d     = '0;
                    vc_d      = '0;
                    uc_d      = '0;
                    cov_d     = 1'b0;
                    gen_d     = '0;
                    state_d   = GEN;
                end
            end
            GEN: begin
                lfsr_en = 1'b1;
                tv_d    = VEC_W'({tv_q, lfsr_word});
                if (gen_q == GEN_LAST) begin
                    ct_d    = '0;
                    ctc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end else begin
                    gen_d = gen_q + 8'd1;
                end
            end
            SCAN: begin
                if (idx_q == FAULT_END) begin
                    state_d = ACCUM;
                end else if (at_q[fidx]) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    set_d   = '0;
                    state_d = INJECT;
                end
            end
            INJECT: begin
                if (set_q == SETTLE_LAST) begin
                    state_d = CMP;
                end else begin
                    set_d = set_q + 16'd1;
                end
            end
            CMP: begin
                if (good_out != fault_out) begin
                    ct_d[fidx] = 1'b1;
                    ctc_d      = ctc_q + 1'b1;
                end
                state_d = REMOVE;
            end
            REMOVE: begin
                idx_d   = idx_q + 1'b1;
                state_d = SCAN;
            end
            ACCUM: begin
                if (ctc_q >= EF_MIN) begin
                    at_d    = at_q | ct_q;
                    det_d   = det_q + ctc_q;
                    uc_d    = '0;
                    state_d = EMIT;
                end else begin
                    if (uc_q != 16'hFFFF) begin
                        uc_d = uc_q + 16'd1;
                    end
                    state_d = CHECK;
                end
            end
            EMIT: begin
                if (vec_ready) begin
                    if (vc_q != 16'hFFFF) begin
                        vc_d = vc_q + 16'd1;
                    end
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cov_lhs >= COV_THR) begin
                    cov_d   = 1'b1;
                    state_d = DONE;
                end else if (uc_q >= UT_MAX) begin
                    state_d = DONE;
                end else begin
                    gen_d   = '0;
                    state_d = GEN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tv_q    <= '0;
            idx_q   <= '0;
            gen_q   <= '0;
            set_q   <= '0;
            ctc_q   <= '0;
            at_q    <= '0;
            ct_q    <= '0;
            det_q   <= '0;
            vc_q    <= '0;
            uc_q    <= '0;
            cov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tv_q    <= tv_d;
            idx_q   <= idx_d;
            gen_q   <= gen_d;
            set_q   <= set_d;
            ctc_q   <= ctc_d;
            at_q    <= at_d;
            ct_q    <= ct_d;
            det_q   <= det_d;
            vc_q    <= vc_d;
            uc_q    <= uc_d;
            cov_q   <= cov_d;
        end
    end

    assign test_vec    = tv_q;
    assign fault_idx   = fidx;
    // Gated by rst so the faulty CUT is released without waiting for the edge
    assign inject      = ((state_q == INJECT) || (state_q == CMP)) && !rst;
    assign vec_valid   = (state_q == EMIT);
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign cov_met     = cov_q;
    assign det_total   = det_q;
    assign vec_count   = vc_q;
    assign useless_cnt = uc_q;

endmodule

// File: tb/tb_rtg_campaign_ctrl.sv
// Scoreboard bench for rtg_campaign_ctrl with a 4-fault list and a
// table-driven fault model keyed on which generated vector is applied.
module tb_rtg_campaign_ctrl;

    localparam int NF = 4;
    localparam int VW = 40;
    localparam int OW = 8;
    localparam int IW = $clog2(NF);

    typedef struct packed {
        logic          kind;
        logic [VW-1:0] vec;
        logic [IW:0]   det;
        logic [15:0]   vc;
        logic [15:0]   uc;
        logic          cov;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   seed;
    logic [VW-1:0] test_vec;
    logic [IW-1:0] fault_idx;
    logic          inject;
    logic [OW-1:0] good_out;
    logic [OW-1:0] fault_out;
    logic          vec_valid;
    logic          vec_ready;
    logic          busy;
    logic          done;
    logic          cov_met;
    logic [IW:0]   det_total;
    logic [15:0]   vec_count;
    logic [15:0]   useless_cnt;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [VW-1:0] exp_vec [8];
    logic [NF-1:0] det_tab [8];
    int            cur_k;
    logic          hit;
    logic          done_q = 1'b0;

    rtg_campaign_ctrl #(
        .NUM_FAULTS (NF),
        .VEC_W      (VW),
        .OUT_W      (OW),
        .EF_COUNT   (1),
        .UT_LIMIT   (3),
        .COV_PCT    (50),
        .SETTLE     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .test_vec    (test_vec),
        .fault_idx   (fault_idx),
        .inject      (inject),
        .good_out    (good_out),
        .fault_out   (fault_out),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .busy        (busy),
        .done        (done),
        .cov_met     (cov_met),
        .det_total   (det_total),
        .vec_count   (vec_count),
        .useless_cnt (useless_cnt)
    );

    always #5 clk = ~clk;

    // Faulty CUT model: flips bit 0 when the injected fault is detectable
    // by the vector currently applied.
    always_comb begin
        cur_k = -1;
        for (int k = 0; k < 8; k++) begin
            if (cur_k < 0 && test_vec == exp_vec[k]) begin
                cur_k = k;
            end
        end
        hit = 1'b0;
        if (inject && cur_k >= 0) begin
            hit = det_tab[cur_k][fault_idx];
        end
    end

    assign fault_out = good_out ^ {{(OW-1){1'b0}}, hit};

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ 32'h8020_0003;
        end
        return n;
    endfunction

    task automatic set_model(input logic [31:0] s);
        logic [31:0] st;
        logic [63:0] acc;
        st = s;
        for (int k = 0; k < 8; k++) begin
            acc = '0;
            for (int w = 0; w < 2; w++) begin
                st  = ref_step(st);
                acc = {acc[31:0], st};
            end
            exp_vec[k] = acc[VW-1:0];
            det_tab[k] = '0;
        end
    endtask

    task automatic exp_emit(input int k, input int det, input int vc);
        exp_t e;
        e      = '0;
        e.kind = 1'b0;
        e.vec  = exp_vec[k];
        e.det  = (IW+1)'(det);
        e.vc   = 16'(vc);
        sb.push_back(e);
    endtask

    task automatic exp_done(input bit cov, input int det, input int vc,
                            input int uc);
        exp_t e;
        e      = '0;
        e.kind = 1'b1;
        e.det  = (IW+1)'(det);
        e.vc   = 16'(vc);
        e.uc   = 16'(uc);
        e.cov  = cov;
        sb.push_back(e);
    endtask

    task automatic kick(input logic [31:0] s);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_done(input string name, output int ucode,
                            output int drop);
        int prev;
        bit fin;
        ucode = 0;
        drop  = 0;
        prev  = int'(useless_cnt);
        fin   = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            if (int'(useless_cnt) != prev) begin
                prev  = int'(useless_cnt);
                ucode = ucode * 10 + prev;
            end
            if (inject && fault_idx == '0 && cur_k == 1) begin
                drop++;
            end
            if (done) begin
                fin = 1'b1;
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s_timeout done=%0b required 1", name, done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending actual %0d required 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per accepted vector and per done rise
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && vec_valid && vec_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL emit_unexpected vec=%h", test_vec);
            end else begin
                e = sb.pop_front();
                if (e.kind != 1'b0 || test_vec !== e.vec ||
                    det_total !== e.det || vec_count !== e.vc) begin
                    errors++;
                    $display("FAIL emit actual vec=%h det=%0d vc=%0d required kind=%0d vec=%h det=%0d vc=%0d",
                             test_vec, det_total, vec_count, e.kind, e.vec,
                             e.det, e.vc);
                end
            end
        end
        if (!rst && done && !done_q) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cov=%0b", cov_met);
            end else begin
                e = sb.pop_front();
                if (e.kind != 1'b1 || cov_met !== e.cov || busy !== 1'b0 ||
                    det_total !== e.det || vec_count !== e.vc ||
                    useless_cnt !== e.uc) begin
                    errors++;
                    $display("FAIL done actual cov=%0b busy=%0b det=%0d vc=%0d uc=%0d required kind=%0d cov=%0b det=%0d vc=%0d uc=%0d",
                             cov_met, busy, det_total, vec_count, useless_cnt,
                             e.kind, e.cov, e.det, e.vc, e.uc);
                end
            end
        end
        done_q = done;
    end

    initial begin
        int  ucode;
        int  drop;
        bit  seen;
        logic [VW-1:0] tv;

        rst       = 1'b1;
        start     = 1'b0;
        seed      = '0;
        vec_ready = 1'b1;
        good_out  = 8'h3C;
        set_model(32'h1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({test_vec, fault_idx, inject, vec_valid, busy, done, cov_met,
             det_total, vec_count, useless_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs vec=%h busy=%0b done=%0b det=%0d required all 0",
                     test_vec, busy, done, det_total);
        end
        @(posedge clk);
        #1;

        // No fault ever detected: three useless vectors then give up
        set_model(32'hACE1_2345);
        exp_done(1'b0, 0, 0, 3);
        kick(32'hACE1_2345);
        run_done("useless", ucode, drop);
        checks++;
        if (ucode != 123) begin
            errors++;
            $display("FAIL useless_seq actual %0d required 123", ucode);
        end

        // Faults 1 and 3 on the first vector reach 50% coverage
        set_model(32'h1234_5678);
        det_tab[0] = 4'b1010;
        exp_emit(0, 2, 0);
        exp_done(1'b1, 2, 1, 0);
        kick(32'h1234_5678);
        run_done("cover", ucode, drop);

        // Fault 0 detected on vector 0 must be dropped on vector 1
        set_model(32'hDEAD_BEEF);
        det_tab[0] = 4'b0001;
        det_tab[1] = 4'b0101;
        exp_emit(0, 1, 0);
        exp_emit(1, 2, 1);
        exp_done(1'b1, 2, 2, 0);
        kick(32'hDEAD_BEEF);
        run_done("dropping", ucode, drop);
        checks++;
        if (drop != 0) begin
            errors++;
            $display("FAIL drop_idx0 actual %0d inject cycles required 0", drop);
        end

        // Back-pressure in EMIT
        set_model(32'h0F0F_1234);
        det_tab[0] = 4'b0010;
        exp_emit(0, 1, 0);
        exp_done(1'b0, 1, 1, 3);
        vec_ready = 1'b0;
        kick(32'h0F0F_1234);
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            seen = vec_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_wait vec_valid=%0b required 1", vec_valid);
        end
        tv = test_vec;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (vec_valid !== 1'b1 || test_vec !== tv || vec_count !== 16'd0) begin
                errors++;
                $display("FAIL stall_hold actual valid=%0b vec=%h vc=%0d required valid=1 vec=%h vc=0",
                         vec_valid, test_vec, vec_count, tv);
            end
        end
        @(posedge clk);
        #1 vec_ready = 1'b1;
        run_done("stall", ucode, drop);

        // Zero seed behaves as seed 1
        set_model(32'h1);
        det_tab[0] = 4'b1010;
        exp_emit(0, 2, 0);
        exp_done(1'b1, 2, 1, 0);
        kick(32'h0);
        run_done("seed0", ucode, drop);
        set_model(32'h1);
        det_tab[0] = 4'b1010;
        exp_emit(0, 2, 0);
        exp_done(1'b1, 2, 1, 0);
        kick(32'h1);
        run_done("seed1", ucode, drop);

        // Reset while injecting on the second vector
        set_model(32'h5555_AAAA);
        det_tab[0] = 4'b0001;
        exp_emit(0, 1, 0);
        kick(32'h5555_AAAA);
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            seen = inject && (cur_k == 1);
        end
        checks++;
        if (!seen || det_total !== 3'd1) begin
            errors++;
            $display("FAIL rst_setup inject=%0b det=%0d required 1 1", seen, det_total);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (inject !== 1'b0) begin
            errors++;
            $display("FAIL rst_inject_now actual %0b required 0", inject);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({inject, busy, done, vec_valid, det_total, vec_count,
             useless_cnt, fault_idx} !== '0 || sb.size() != 0) begin
            errors++;
            $display("FAIL rst_mid actual inject=%0b busy=%0b det=%0d pending=%0d required 0",
                     inject, busy, det_total, sb.size());
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_model(32'h5555_AAAA);
        det_tab[0] = 4'b1010;
        exp_emit(0, 2, 0);
        exp_done(1'b1, 2, 1, 0);
        kick(32'h5555_AAAA);
        run_done("after_rst", ucode, drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtg_campaign_ctrl.md
Name: rtg_campaign_ctrl

Overview:
- Synthesizable sequencer for a random-test-generation fault-simulation campaign on a CUT and its fault-injectable copy.
- Generates pseudo-random test vectors and walks the fault list, skipping already-detected faults (fault dropping).
- For each fault it requests injection, waits for settling, compares good and faulty outputs, and accumulates per-vector and global detections.
- It emits useful vectors over a valid/ready handshake, and stops on a coverage target or a useless-vector limit.

Parameters:
- NUM_FAULTS, 1798, number of faults in the list (indices 0..NUM_FAULTS-1)
- VEC_W, 157, test vector width
- OUT_W, 64, CUT output width
- EF_COUNT, 1, minimum new detections for a vector to count as useful
- UT_LIMIT, 300, consecutive useless vectors before giving up
- COV_PCT, 95, target coverage in percent
- SETTLE, 6, cycles between injection and compare (minimum 1)
- IDX_W, $clog2(NUM_FAULTS), fault index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; launches a campaign from IDLE, ignored otherwise
- seed  in  32  LFSR seed, sampled on start; 0 is replaced by 32'h1
- test_vec  out  VEC_W  vector applied to both CUTs
- fault_idx  out  IDX_W  fault currently selected
- inject  out  1  high while the fault at fault_idx must be active in the faulty CUT
- good_out  in  OUT_W  fault-free CUT outputs
- fault_out  in  OUT_W  faulty CUT outputs
- vec_valid  out  1  useful vector available on test_vec
- vec_ready  in  1  sink accepts vector
- busy  out  1  campaign running
- done  out  1  campaign finished, held until next start
- cov_met  out  1  done was reached by meeting coverage
- det_total  out  IDX_W+1  globally detected faults
- vec_count  out  16  useful vectors emitted
- useless_cnt  out  16  current consecutive useless count

Behaviour:
- Reset: all outputs 0; state IDLE; both detection bitmaps (AT global, CT current vector) cleared; LFSR = 32'h1.
- PRNG: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003), advances once per cycle in GEN only.
- IDLE: on start, load seed, clear AT, det_total, vec_count and useless_cnt, clear done and cov_met, set busy, go to GEN.
- GEN: ceil(VEC_W/32) cycles. Each cycle shift test_vec left 32 and OR in the LFSR word; truncate to VEC_W. Then clear CT and ct_cnt, set fault_idx=0, go to SCAN.
- SCAN: one index per cycle.
  - If AT[fault_idx]=1, increment fault_idx.
  - If fault_idx reaches NUM_FAULTS, go to ACCUM.
  - Otherwise go to INJECT.
- INJECT: inject=1 for SETTLE cycles, then CMP.
- CMP: inject stays 1. If good_out != fault_out, set CT[fault_idx] and increment ct_cnt. Go to REMOVE.
- REMOVE: inject=0 for 1 cycle, increment fault_idx, go to SCAN.
- ACCUM: 1 cycle.
  - If ct_cnt >= EF_COUNT: AT |= CT, det_total += ct_cnt, useless_cnt=0, go to EMIT.
  - Else: useless_cnt++, go to CHECK.
- EMIT: vec_valid=1 with test_vec stable. On vec_valid&&vec_ready, vec_count++ (saturating) and go to CHECK. Stalls indefinitely while vec_ready=0.
- CHECK:
  - If det_total*100 >= COV_PCT*NUM_FAULTS: cov_met=1, go to DONE.
  - Else if useless_cnt >= UT_LIMIT: go to DONE.
  - Else go to GEN.
  - Use (IDX_W+8)-bit products; no truncation.
- DONE: busy=0, done=1; start restarts the campaign as from IDLE.
- start while busy is ignored.
- rst in any state, including mid-EMIT or with inject=1, returns to reset values the next cycle; inject drops immediately.
- All faults detected: SCAN skips every index, ACCUM sees ct_cnt=0. Coverage is already met at the prior CHECK, so this path is unreachable except when COV_PCT > 100.

Decomposition:
- Shared package rtg_pkg holds: state enum (IDLE, GEN, SCAN, INJECT, CMP, REMOVE, ACCUM, EMIT, CHECK, DONE), LFSR mask constant, and the seed-zero substitute constant.
- One sub-module, rtg_lfsr32: enable, load, seed, 32-bit state out.

Test Plan:
- NUM_FAULTS=4, SETTLE=2, fault_out=good_out for all faults, UT_LIMIT=3 -> three GEN/SCAN passes, useless_cnt 1,2,3, done=1, cov_met=0, vec_count=0, no vec_valid.
- NUM_FAULTS=4, COV_PCT=50, model detects faults 1 and 3 on the first vector -> det_total=2, one vec_valid, vec_count=1, done with cov_met=1.
- Fault dropping: model detects fault 0 on vector 1 and fault 2 on vector 2; check inject is never asserted for index 0 during vector 2; det_total=2.
- vec_ready held low for 20 cycles in EMIT -> vec_valid stays 1 with test_vec constant; accepted on the cycle ready rises; vec_count increments once.
- seed=0 -> LFSR loads 32'h1; first GEN word equals the reference LFSR step from 1; same result as seed=1.
- rst asserted during INJECT -> next cycle inject=0, busy=0, det_total=0, state IDLE; a new start runs normally.
